multicycle_control: RTL

Multi-cycle main controller that sequences the shared MIPS datapath (one ALU, one unified memory port, register file) through fetch, decode, execute, memory and write-back steps, one instruction at a time.
Replaces the single-cycle opcode decoder and drives every datapath mux select, write enable and ALUOp.
Waits on a memory ready handshake and traps on illegal opcodes or memory timeouts.

---
 rtl/multicycle_control_if.sv | 40 ++++
 rtl/multicycle_control.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control_if.sv
// rtl/multicycle_control_if.sv - controller <-> datapath signal bundle for the multi-cycle MIPS controller
interface multicycle_control_if #(
    parameter int CNT_W = 32
);
    logic [5:0]       opcode;
    logic             Zero;
    logic             MemReady;
    logic             PCWriteEn;
    logic             IorD;
    logic             MemRead;
    logic             MemWrite;
    logic             IRWrite;
    logic             MemtoReg;
    logic             RegDst;
    logic             RegWrite;
    logic             ALUSrcA;
    logic [1:0]       ALUSrcB;
    logic [1:0]       ALUOp;
    logic [1:0]       PCSource;
    logic             Illegal;
    logic             BusErr;
    logic [3:0]       State;
    logic [CNT_W-1:0] InstrCount;

    // Controller side: consumes datapath status, drives every select and enable
    modport master (
        input  opcode, Zero, MemReady,
        output PCWriteEn, IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegDst,
               RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource, Illegal, BusErr,
               State, InstrCount
    );

    // Datapath side: the mirror image of the controller
    modport slave (
        output opcode, Zero, MemReady,
        input  PCWriteEn, IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegDst,
               RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource, Illegal, BusErr,
               State, InstrCount
    );
endinterface

// File: rtl/multicycle_control.sv
// rtl/multicycle_control.sv - multi-cycle MIPS main controller with memory-timeout and illegal-opcode traps
module multicycle_control #(
    parameter int CNT_W       = 32,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic                 CLK,
    input  logic                 RESET,
    multicycle_control_if.master bus
);
    localparam logic [3:0] FETCH   = 4'd0;
    localparam logic [3:0] DECODE  = 4'd1;
    localparam logic [3:0] MEMADR  = 4'd2;
    localparam logic [3:0] MEMRD   = 4'd3;
    localparam logic [3:0] MEMWB   = 4'd4;
    localparam logic [3:0] MEMWR   = 4'd5;
    localparam logic [3:0] EXEC    = 4'd6;
    localparam logic [3:0] RWB     = 4'd7;
    localparam logic [3:0] BRANCH  = 4'd8;
    localparam logic [3:0] ADDI_EX = 4'd9;
    localparam logic [3:0] ADDI_WB = 4'd10;
    localparam logic [3:0] JUMP    = 4'd11;
    localparam logic [3:0] TRAP    = 4'd15;

    localparam logic [5:0] OP_RTYPE = 6'd0;
    localparam logic [5:0] OP_J     = 6'd2;
    localparam logic [5:0] OP_BEQ   = 6'd4;
    localparam logic [5:0] OP_BNE   = 6'd5;
    localparam logic [5:0] OP_ADDI  = 6'd8;
    localparam logic [5:0] OP_LW    = 6'd35;
    localparam logic [5:0] OP_SW    = 6'd43;

    localparam logic [7:0]       TIMEOUT = 8'(MEM_TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [3:0]       state_q, state_d;
    logic [7:0]       wait_q, wait_d;
    logic             illegal_q, illegal_d;
    logic             buserr_q, buserr_d;
    logic             bne_q, bne_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             mem_state;
    logic             timeout;

    // States that talk to memory and are therefore subject to the wait watchdog
    assign mem_state = (state_q == FETCH) || (state_q == MEMRD) || (state_q == MEMWR);
    // A ready in the same cycle as the limit still completes the access
    assign timeout   = mem_state && !bus.MemReady && (wait_q == TIMEOUT);

    // Next-state, trap flags, retired count and branch-sense capture
    always_comb begin
        state_d   = state_q;
        illegal_d = illegal_q;
        buserr_d  = buserr_q;
        bne_d     = bne_q;
        count_d   = count_q;
        case (state_q)
            FETCH: begin
                if (bus.MemReady) begin
                    state_d = DECODE;
                    count_d = count_q + CNT_ONE;
                end
            end
            DECODE: begin
                // Branch sense is latched here so BRANCH never looks at opcode
                bne_d = (bus.opcode == OP_BNE);
                case (bus.opcode)
                    OP_RTYPE:      state_d = EXEC;
                    OP_LW, OP_SW:  state_d = MEMADR;
                    OP_BEQ, OP_BNE: state_d = BRANCH;
                    OP_ADDI:       state_d = ADDI_EX;
                    OP_J:          state_d = JUMP;
                    default: begin
                        state_d   = TRAP;
                        illegal_d = 1'b1;
                    end
                endcase
            end
            MEMADR: begin
                if (bus.opcode == OP_LW) begin
                    state_d = MEMRD;
                end else if (bus.opcode == OP_SW) begin
                    state_d = MEMWR;
                end else begin
                    // Opcode changed under us: treat as illegal rather than guess
                    state_d   = TRAP;
                    illegal_d = 1'b1;
                end
            end
            MEMRD:   if (bus.MemReady) state_d = MEMWB;
            MEMWR:   if (bus.MemReady) state_d = FETCH;
            EXEC:    state_d = RWB;
            ADDI_EX: state_d = ADDI_WB;
            MEMWB, RWB, BRANCH, ADDI_WB, JUMP: state_d = FETCH;
            TRAP:    state_d = TRAP;
            default: state_d = TRAP;
        endcase
        if (timeout) begin
            state_d  = TRAP;
            buserr_d = 1'b1;
        end
    end

    // Wait counter: zero on any state change or ready, counts stalled memory cycles
    always_comb begin
        wait_d = 8'd0;
        if (mem_state && !bus.MemReady && (state_d == state_q)) begin
            wait_d = wait_q + 8'd1;
        end
    end

    // State and status registers with asynchronous clear
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q   <= FETCH;
            wait_q    <= 8'd0;
            illegal_q <= 1'b0;
            buserr_q  <= 1'b0;
            bne_q     <= 1'b0;
            count_q   <= '0;
        end else begin
            state_q   <= state_d;
            wait_q    <= wait_d;
            illegal_q <= illegal_d;
            buserr_q  <= buserr_d;
            bne_q     <= bne_d;
            count_q   <= count_d;
        end
    end

    // Moore decode of datapath controls; only PCWriteEn and IRWrite see MemReady/Zero
    always_comb begin
        bus.PCWriteEn = 1'b0;
        bus.IorD      = 1'b0;
        bus.MemRead   = 1'b0;
        bus.MemWrite  = 1'b0;
        bus.IRWrite   = 1'b0;
        bus.MemtoReg  = 1'b0;
        bus.RegDst    = 1'b0;
        bus.RegWrite  = 1'b0;
        bus.ALUSrcA   = 1'b0;
        bus.ALUSrcB   = 2'b00;
        bus.ALUOp     = 2'b00;
        bus.PCSource  = 2'b00;
        case (state_q)
            FETCH: begin
                bus.MemRead   = 1'b1;
                bus.ALUSrcB   = 2'b01;
                bus.IRWrite   = bus.MemReady;
                bus.PCWriteEn = bus.MemReady;
            end
            DECODE:  bus.ALUSrcB = 2'b11;
            MEMADR, ADDI_EX: begin
                bus.ALUSrcA = 1'b1;
                bus.ALUSrcB = 2'b10;
            end
            MEMRD: begin
                bus.MemRead = 1'b1;
                bus.IorD    = 1'b1;
            end
            MEMWB: begin
                bus.RegWrite = 1'b1;
                bus.MemtoReg = 1'b1;
            end
            MEMWR: begin
                bus.MemWrite = 1'b1;
                bus.IorD     = 1'b1;
            end
            EXEC: begin
                bus.ALUSrcA = 1'b1;
                bus.ALUOp   = 2'b10;
            end
            RWB: begin
                bus.RegWrite = 1'b1;
                bus.RegDst   = 1'b1;
            end
            BRANCH: begin
                bus.ALUSrcA   = 1'b1;
                bus.ALUOp     = 2'b01;
                bus.PCSource  = 2'b01;
                bus.PCWriteEn = bne_q ? !bus.Zero : bus.Zero;
            end
            ADDI_WB: bus.RegWrite = 1'b1;
            JUMP: begin
                bus.PCWriteEn = 1'b1;
                bus.PCSource  = 2'b10;
            end
            default: ;
        endcase
    end

    assign bus.Illegal    = illegal_q;
    assign bus.BusErr     = buserr_q;
    assign bus.State      = state_q;
    assign bus.InstrCount = count_q;
endmodule
